// File: rtl/stream_seq_checker.sv
// Terminal sink for an incrementing-sequence stream. Drives registered
// backpressure from an external ready pattern, checks payload order and
// the valid/ready stall protocol, and reports pass/error counts.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | first cycle after reset release; ready starts tracking ready_in
// RUN   | every accepted beat and every stall is checked
// DONE  | NUM_CHECK beats seen; ready forced low, checking frozen
module stream_seq_checker #(
   parameter int WIDTH     = 9,
   parameter int DEPTH     = 256,
   parameter int NUM_CHECK = 300,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             s_rst,
   input  logic             vaild,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   input  logic             ready_in,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_flag,
   output logic [WIDTH-1:0] first_err_data,
   output logic [WIDTH-1:0] first_err_exp,
   output logic             done
);

   localparam int BEAT_W = $clog2(NUM_CHECK + 1);
   localparam logic [WIDTH-1:0]  EXP_LAST  = WIDTH'(DEPTH - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_CHECK - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  exp_val;
   logic [BEAT_W-1:0] beat_cnt;
   logic              prev_vaild;
   logic              prev_ready;
   logic [WIDTH-1:0]  prev_data;
   logic              seq_seen;

   logic       chk_beat;
   logic       seq_ok;
   logic       seq_err;
   logic       stall_prev;
   logic       proto_err;
   logic       last_beat;
   logic [1:0] err_inc;

   function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
      return (v == EXP_LAST) ? '0 : v + WIDTH'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W+1:0] s;
      s = {2'b00, a} + {{CNT_W{1'b0}}, b};
      if (s > {2'b00, CNT_MAX})
         return CNT_MAX;
      return s[CNT_W-1:0];
   endfunction

   // Beats are only judged in RUN; a stall is a cycle with valid high and ready low.
   assign chk_beat   = (state == S_RUN) && vaild && ready;
   assign seq_ok     = (data_in == exp_val);
   assign seq_err    = chk_beat && !seq_ok;
   assign stall_prev = prev_vaild && !prev_ready;
   assign proto_err  = (state == S_RUN) && stall_prev &&
                       (!vaild || (data_in != prev_data));
   assign last_beat  = chk_beat && (beat_cnt == BEAT_LAST);
   assign err_inc    = 2'(seq_err) + 2'(proto_err);

   // State register.
   always_ff @(posedge clk or posedge s_rst) begin
      if (s_rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: IDLE lasts one cycle, RUN ends on the NUM_CHECK-th beat.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_RUN;
         S_RUN:   if (last_beat) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      done = (state == S_DONE);
   end

   // Registered backpressure: one cycle behind ready_in, held low once DONE.
   always_ff @(posedge clk or posedge s_rst) begin
      if (s_rst)
         ready <= 1'b0;
      else
         ready <= (state == S_DONE) ? 1'b0 : ready_in;
   end

   // Previous-cycle handshake snapshot for the stall rules.
   always_ff @(posedge clk or posedge s_rst) begin
      if (s_rst) begin
         prev_vaild <= 1'b0;
         prev_ready <= 1'b0;
         prev_data  <= '0;
      end else begin
         prev_vaild <= vaild;
         prev_ready <= ready;
         prev_data  <= data_in;
      end
   end

   // Sequence tracking, counters and first-error capture.
   always_ff @(posedge clk or posedge s_rst) begin
      if (s_rst) begin
         exp_val        <= '0;
         beat_cnt       <= '0;
         pass_cnt       <= '0;
         err_cnt        <= '0;
         err_flag       <= 1'b0;
         seq_seen       <= 1'b0;
         first_err_data <= '0;
         first_err_exp  <= '0;
      end else begin
         if (chk_beat) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (seq_ok) begin
               pass_cnt <= sat_add(pass_cnt, 2'd1);
               exp_val  <= wrap_inc(exp_val);
            end else begin
               // Resync to the observed value so one glitch costs one error.
               exp_val <= wrap_inc(data_in);
               if (!seq_seen) begin
                  seq_seen       <= 1'b1;
                  first_err_data <= data_in;
                  first_err_exp  <= exp_val;
               end
            end
         end
         if (err_inc != 2'd0) begin
            err_cnt  <= sat_add(err_cnt, err_inc);
            err_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed bench for stream_seq_checker: in-order streams, wrap, sequence
// error with resync, both stall-protocol rules, combined errors, random
// handshake with ready latency tracking, and asynchronous reset mid-stream.
module tb_stream_seq_checker;

   localparam int WIDTH = 9;
   localparam int CNT_W = 16;

   logic             clk;
   logic             s_rst;
   logic             vaild;
   logic [WIDTH-1:0] data_in;
   logic             ready;
   logic             ready_in;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic             err_flag;
   logic [WIDTH-1:0] first_err_data;
   logic [WIDTH-1:0] first_err_exp;
   logic             done;

   int n_chk = 0;
   int n_err = 0;
   logic rnd_run = 1'b0;

   stream_seq_checker #(
      .WIDTH(WIDTH), .DEPTH(256), .NUM_CHECK(300), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .s_rst(s_rst), .vaild(vaild), .data_in(data_in),
      .ready(ready), .ready_in(ready_in), .pass_cnt(pass_cnt),
      .err_cnt(err_cnt), .err_flag(err_flag),
      .first_err_data(first_err_data), .first_err_exp(first_err_exp),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reset held across two falling edges, released on a falling edge.
   task automatic do_reset(input logic rin);
      s_rst    = 1'b1;
      vaild    = 1'b0;
      data_in  = '0;
      ready_in = rin;
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
   endtask

   // Present one beat and hold it until the edge that accepts it.
   task automatic send(input int d);
      int n;
      n = 0;
      vaild   = 1'b1;
      data_in = WIDTH'(d);
      while (ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100)
         chk("send_timeout", n, 0);
      else
         @(negedge clk);
   endtask

   task automatic chk_counts(input string tag, input int p, input int e, input logic f);
      chk({tag, "_pass"}, pass_cnt, p);
      chk({tag, "_err"},  err_cnt,  e);
      chk({tag, "_flag"}, err_flag, f);
   endtask

   initial begin
      s_rst    = 1'b1;
      vaild    = 1'b0;
      data_in  = '0;
      ready_in = 1'b1;
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_done",  done,  0);
      chk("rst_fed",   first_err_data, 0);
      chk("rst_fee",   first_err_exp,  0);
      chk_counts("rst", 0, 0, 0);

      // In-order 0..299 back-to-back (wraps through 255 -> 0 on the way).
      do_reset(1'b1);
      chk("idle_ready", ready, 0);
      for (int i = 0; i < 299; i++) send(i % 256);
      chk("pre_done", done, 0);
      send(299 % 256);
      vaild = 1'b0;
      chk("done_rise", done, 1);
      chk_counts("full", 300, 0, 0);
      repeat (2) @(negedge clk);
      chk("done_ready", ready, 0);
      vaild = 1'b1;
      data_in = WIDTH'(44);
      repeat (3) @(negedge clk);
      vaild = 1'b0;
      chk_counts("after_done", 300, 0, 0);
      chk("done_hold", done, 1);

      // Wrap: 0..261 reaches 250..255,0..5 with no error.
      do_reset(1'b1);
      for (int i = 0; i < 262; i++) send(i % 256);
      vaild = 1'b0;
      chk_counts("wrap", 262, 0, 0);
      chk("wrap_done", done, 0);

      // Sequence error with resync.
      do_reset(1'b1);
      send(0); send(1); send(2); send(7); send(8);
      vaild = 1'b0;
      chk_counts("seq", 4, 1, 1);
      chk("seq_fed", first_err_data, 7);
      chk("seq_fee", first_err_exp,  3);

      // Rule A: valid dropped during a stall.
      do_reset(1'b0);
      @(negedge clk);
      vaild = 1'b1;
      data_in = WIDTH'(5);
      repeat (3) @(negedge clk);
      chk("ruleA_stall", err_cnt, 0);
      vaild = 1'b0;
      @(negedge clk);
      chk_counts("ruleA", 0, 1, 1);
      repeat (2) @(negedge clk);
      chk("ruleA_hold", err_cnt, 1);

      // Rule B: data changed during a stall.
      do_reset(1'b0);
      @(negedge clk);
      vaild = 1'b1;
      data_in = WIDTH'(5);
      repeat (3) @(negedge clk);
      chk("ruleB_stall", err_cnt, 0);
      data_in = WIDTH'(6);
      @(negedge clk);
      chk_counts("ruleB", 0, 1, 1);
      @(negedge clk);
      chk("ruleB_hold", err_cnt, 1);
      chk("ruleB_fed", first_err_data, 0);

      // Sequence error and Rule B on the same edge count twice.
      do_reset(1'b0);
      @(negedge clk);
      vaild = 1'b1;
      data_in = WIDTH'(5);
      @(negedge clk);
      ready_in = 1'b1;
      @(negedge clk);
      chk("dbl_ready", ready, 1);
      data_in = WIDTH'(6);
      @(negedge clk);
      vaild = 1'b0;
      chk_counts("dbl", 0, 2, 1);
      chk("dbl_fed", first_err_data, 6);
      chk("dbl_fee", first_err_exp,  0);

      // Random ready pattern and random source gaps; ready tracked one cycle behind.
      do_reset(1'b1);
      rnd_run = 1'b1;
      fork
         begin
            logic last_rin;
            last_rin = ready_in;
            while (rnd_run) begin
               @(negedge clk);
               if (rnd_run && !done) chk("rdy_lat", ready, last_rin);
               last_rin = ($urandom_range(0, 3) != 0);
               ready_in = last_rin;
            end
         end
      join_none
      for (int i = 0; i < 300; i++) begin
         send(i % 256);
         vaild = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rnd_run = 1'b0;
      repeat (2) @(negedge clk);
      chk_counts("rnd", 300, 0, 0);
      chk("rnd_done", done, 1);

      // Asynchronous reset after 50 beats, then a fresh stream.
      do_reset(1'b1);
      for (int i = 0; i < 50; i++) send(i);
      vaild = 1'b0;
      chk("mid_pass50", pass_cnt, 50);
      #2 s_rst = 1'b1;
      #1;
      chk("mid_rst_pass",  pass_cnt, 0);
      chk("mid_rst_ready", ready, 0);
      chk("mid_rst_done",  done, 0);
      chk("mid_rst_flag",  err_flag, 0);
      @(negedge clk);
      s_rst = 1'b0;
      chk("mid_idle_ready", ready, 0);
      for (int i = 0; i < 10; i++) send(i);
      vaild = 1'b0;
      chk_counts("restart", 10, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule
